// File: rtl/io_fifo_bridge.sv
// io_fifo_bridge
// Connects the single-cycle core's I/O words to an external device.
//   Output path: core stores go into a DEPTH-entry circular FIFO. The FIFO is
//                drained by the device through a valid/ready handshake.
//   Input path : device words are captured into a one-entry holding register.
//                That register drives the core's read_in.
// Ports:
//   clock, rst                   clock and asynchronous active-low reset
//   cpu_wr_en, cpu_wr_data       core store to the output I/O address
//   cpu_rd_en                    core load from the input I/O address (consumes)
//   read_in, in_avail            held input word and its "unconsumed" flag
//   out_full, overflow           FIFO full / sticky "core write was dropped"
//   dev_out_data/valid/ready     FIFO head handshake towards the device
//   dev_in_data/valid/ready      device word handshake into the holding register
module io_fifo_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cpu_wr_en,
  input  logic [WIDTH-1:0] cpu_wr_data,
  input  logic             cpu_rd_en,
  output logic [WIDTH-1:0] read_in,
  output logic             in_avail,
  output logic             out_full,
  output logic             overflow,
  output logic [WIDTH-1:0] dev_out_data,
  output logic             dev_out_valid,
  input  logic             dev_out_ready,
  input  logic [WIDTH-1:0] dev_in_data,
  input  logic             dev_in_valid,
  output logic             dev_in_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_STEP = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             overflow_reg;
  logic             in_avail_reg;
  logic [WIDTH-1:0] read_in_reg;

  logic empty, full, pop, push, capture, consume;

  // The pointers carry one extra MSB. Equal low bits with different MSBs
  // means the write pointer has lapped the read pointer, so the FIFO is full.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  assign pop  = !empty && dev_out_ready;
  // When full, a write can still be accepted if a pop frees a slot in the
  // same cycle.
  assign push = cpu_wr_en && (!full || pop);

  // The holding register accepts a device word only while it is empty.
  // Because of this, capture and consume never coincide.
  assign capture = dev_in_valid && !in_avail_reg;
  assign consume = cpu_rd_en && in_avail_reg;

  // Storage is not reset. The head read is combinational, so a popped
  // entry is replaced by the next head right after the edge.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_STEP;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_STEP;
      end
      if (cpu_wr_en && !push) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      in_avail_reg <= 1'b0;
      read_in_reg  <= '0;
    end else begin
      if (capture) begin
        in_avail_reg <= 1'b1;
        read_in_reg  <= dev_in_data;
      end else if (consume) begin
        // read_in keeps the consumed word until the next capture.
        in_avail_reg <= 1'b0;
      end
    end
  end

  assign dev_out_valid = !empty;
  assign dev_out_data  = mem[rd_ptr_reg[AW-1:0]];
  assign out_full      = full;
  assign overflow      = overflow_reg;
  assign in_avail      = in_avail_reg;
  assign read_in       = read_in_reg;
  assign dev_in_ready  = !in_avail_reg;

endmodule

// File: doc/io_fifo_bridge.md
# io_fifo_bridge

Buffered I/O bridge between the single-cycle core's 16-bit I/O words (its `write_out` output and `read_in` input) and an external device. Core output words go into a DEPTH-entry FIFO drained by a valid/ready handshake. Device input words are captured into a one-entry holding register that drives the core's `read_in`. The block decouples the one-instruction-per-clock core from a device that may stall or deliver data sporadically.

## Interface
Parameters:
- `WIDTH`, 16, data word width
- `DEPTH`, 4, output FIFO entries; power of two, ≥2

Ports:
- `clock`  in  1  single clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to `clock` at system level
- `cpu_wr_en`  in  1  core stores to the output I/O address this cycle
- `cpu_wr_data`  in  WIDTH  word stored by core (core `write_out`)
- `cpu_rd_en`  in  1  core loads from the input I/O address this cycle (consumes held word)
- `read_in`  out  WIDTH  held input word to core `read_in`
- `in_avail`  out  1  holding register contains an unconsumed word
- `out_full`  out  1  output FIFO holds DEPTH words
- `overflow`  out  1  sticky: a core write was dropped
- `dev_out_data`  out  WIDTH  FIFO head word
- `dev_out_valid`  out  1  FIFO non-empty
- `dev_out_ready`  in  1  device accepts head word this cycle
- `dev_in_data`  in  WIDTH  device word
- `dev_in_valid`  in  1  device offers word
- `dev_in_ready`  out  1  bridge can accept device word

## Operation
- Output FIFO: circular storage, read/write pointers of log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Pointers wrap from DEPTH-1 to 0 with the MSB toggled.
- pop = `dev_out_valid && dev_out_ready`. Read pointer advances.
- push = `cpu_wr_en && (!out_full || pop)`. Stores `cpu_wr_data` at the write pointer, which then advances.
  - When full, a write is accepted only if a pop happens in the same cycle.
- `cpu_wr_en` while full with no pop: the word is dropped, pointers are unchanged, and `overflow` is set to 1. `overflow` stays 1 until reset.
- Simultaneous push and pop when empty is impossible, because pop requires valid. The pushed word becomes the head.
- `dev_out_valid` = !empty. `dev_out_data` = storage[read pointer low bits]; its value is don't-care when empty.
- `dev_out_data` must hold stable while `dev_out_valid && !dev_out_ready`.
- Input holding register:
  - `dev_in_ready` = !`in_avail`.
  - Capture when `dev_in_valid && dev_in_ready`: `read_in` ← `dev_in_data`, `in_avail` ← 1.
- `cpu_rd_en && in_avail` clears `in_avail`.
  - `read_in` keeps its value after consumption; it changes only on the next capture.
- `cpu_rd_en` with `in_avail`=0 has no effect. `read_in` returns the stale word; software polls `in_avail`.
- No capture occurs in the cycle the word is consumed, because `dev_in_ready` was 0. Maximum input throughput is one word per 2 cycles.
- Reset (`rst`=0, any time, including mid-transfer):
  - Both pointers go to 0 and the FIFO is empty; stored words are lost.
  - `read_in`=0, `in_avail`=0, `overflow`=0.
  - Storage contents need not be cleared.

## Timing
- Reset values: `read_in`=0, `in_avail`=0, `out_full`=0, `overflow`=0, `dev_out_valid`=0, `dev_in_ready`=1. `dev_out_data` is don't-care.
- Push at edge N: `dev_out_valid`=1 after edge N, so a word is visible to the device one cycle after the core writes it.
- Pop at edge N: the next head word is presented after edge N. Back-to-back pops sustain one word per cycle.
- Flags `out_full`, `dev_out_valid`, `in_avail` and `overflow` are derived from registered state only. None combinationally depend on `cpu_wr_en` or `dev_out_ready` of the same cycle.
- Capture at edge N: `in_avail`=1 and `read_in` valid after edge N, so the core can load it in cycle N+1.
- `dev_in_ready` depends on registered `in_avail` only; there is no combinational path from `dev_in_valid`.

## Test plan
- Reset then idle: all outputs match reset values; assert `rst` mid-stream with 3 words queued → `dev_out_valid`=0 immediately and `in_avail`=0.
- Core writes 0x0001, 0x0002, 0x0003 on consecutive cycles with `dev_out_ready`=1 → device receives 1, 2, 3 in order, one per cycle, starting one cycle after the first write.
- `dev_out_ready`=0; write 0xA0..0xA4 (5 words, DEPTH=4):
  - `out_full`=1 after the 4th write; 0xA4 is dropped and `overflow`=1.
  - Release ready → 0xA0..0xA3 drain in order, wrap-around is exercised, and `overflow` stays 1.
- Full FIFO, same cycle `cpu_wr_en`=1 (0xBEEF) and `dev_out_ready`=1 → head is popped, 0xBEEF accepted, `out_full` stays 1, `overflow` not set.
- Device offers 0x1234 → `in_avail`=1 and `read_in`=0x1234 next cycle.
  - 0x5678 is held off (`dev_in_ready`=0) until `cpu_rd_en`; it is captured the cycle after consumption.
  - `cpu_rd_en` with `in_avail`=0 leaves the state unchanged.
- Run 20 random-gap writes with random `dev_out_ready` → output sequence equals the accepted input sequence, and `dev_out_data` is stable during stalls.
